cpu_clk_ctrl: RTL and testbench

CPU_CLK_CTRL -- requirements
Module: cpu_clk_ctrl

---
 rtl/cpu_clk_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_cpu_clk_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_clk_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_clk_ctrl
//
// Generates the clock-enable that advances the CPU. There are two execution
// modes: continuous (run) and single-step (a debounced pushbutton). Each
// accepted rising edge of the divided clock tick_in produces a one-cycle
// cpu_en pulse, and cycle_cnt counts every pulse that is issued.
//
// Parameters
//   DEBOUNCE_CYCLES  stable clk_in cycles needed before the step level changes
//   CNT_W            width of cycle_cnt
//
// Ports
//   clk_in     in   system clock; every flop is rising-edge clk_in
//   rst_n      in   asynchronous active-low reset
//   tick_in    in   divided clock, asynchronous to clk_in
//   run        in   level request for continuous execution
//   step_btn   in   raw single-step pushbutton (asynchronous, bouncing)
//   halt       in   CPU halt indication, level
//   cnt_clr    in   synchronous clear of cycle_cnt
//   cpu_en     out  one-cycle CPU clock-enable pulse
//   cycle_cnt  out  number of cpu_en pulses issued (wraps)
//   state      out  IDLE=00, RUN=01, STEP=10, HALTED=11
// ---------------------------------------------------------------------------
module cpu_clk_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned CNT_W           = 32
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             tick_in,
    input  logic             run,
    input  logic             step_btn,
    input  logic             halt,
    input  logic             cnt_clr,
    output logic             cpu_en,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StRun    = 2'b01,
        StStep   = 2'b10,
        StHalted = 2'b11
    } state_e;

    localparam int unsigned DbW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DbW-1:0] DbMax =
        (DEBOUNCE_CYCLES > 0) ? DbW'(DEBOUNCE_CYCLES - 1) : '0;

    // -----------------------------------------------------------------------
    // tick_in synchronizer and edge detector
    // -----------------------------------------------------------------------
    logic       tick_s1_q, tick_s2_q, tick_s3_q;
    logic [1:0] tick_fill_q;
    logic       tick_arm_q;
    logic       tick_rise;

    // The reset values of s2/s3 are not real samples. Edge detection is
    // armed only once s3 has captured a genuine low, so a tick_in that is
    // already high when reset releases is never mistaken for a new edge.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            tick_s1_q   <= 1'b0;
            tick_s2_q   <= 1'b0;
            tick_s3_q   <= 1'b0;
            tick_fill_q <= 2'd0;
            tick_arm_q  <= 1'b0;
        end else begin
            tick_s1_q <= tick_in;
            tick_s2_q <= tick_s1_q;
            tick_s3_q <= tick_s2_q;
            if (tick_fill_q != 2'd2) begin
                tick_fill_q <= tick_fill_q + 2'd1;
            end
            // s2 holds a real sample once the fill count reaches 2.
            if ((tick_fill_q == 2'd2) && !tick_s2_q) begin
                tick_arm_q <= 1'b1;
            end
        end
    end

    assign tick_rise = tick_s2_q & ~tick_s3_q & tick_arm_q;

    // -----------------------------------------------------------------------
    // step_btn synchronizer, debounce and press detector
    // -----------------------------------------------------------------------
    logic           btn_s1_q, btn_s2_q, btn_s3_q;
    logic [DbW-1:0] db_cnt_q;
    logic           db_level_q;
    logic           db_prev_q;
    logic           step_req;

    // btn_s3 is the history of the synchronized level; any change reloads
    // the counter, and the counter saturates once the level is accepted.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1_q   <= 1'b0;
            btn_s2_q   <= 1'b0;
            btn_s3_q   <= 1'b0;
            db_cnt_q   <= '0;
            db_level_q <= 1'b0;
            db_prev_q  <= 1'b0;
        end else begin
            btn_s1_q  <= step_btn;
            btn_s2_q  <= btn_s1_q;
            btn_s3_q  <= btn_s2_q;
            db_prev_q <= db_level_q;
            if (btn_s2_q != btn_s3_q) begin
                db_cnt_q <= '0;
            end else if (db_cnt_q == DbMax) begin
                db_level_q <= btn_s3_q;
            end else begin
                db_cnt_q <= db_cnt_q + 1'b1;
            end
        end
    end

    // Press only: releases never request a step.
    assign step_req = db_level_q & ~db_prev_q;

    // -----------------------------------------------------------------------
    // Control FSM (priority halt > run > step_req in every state)
    // -----------------------------------------------------------------------
    state_e state_q, state_d;
    logic   cpu_en_q, cpu_en_d;

    always_comb begin
        state_d  = state_q;
        cpu_en_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (halt) begin
                    state_d = StHalted;
                end else if (run) begin
                    state_d = StRun;
                end else if (step_req) begin
                    state_d = StStep;
                end
            end
            StRun: begin
                if (halt) begin
                    state_d = StHalted;
                end else if (!run) begin
                    state_d = StIdle;
                end else if (tick_rise) begin
                    cpu_en_d = 1'b1;
                end
            end
            StStep: begin
                if (halt) begin
                    state_d = StHalted;
                end else begin
                    if (tick_rise) begin
                        cpu_en_d = 1'b1;
                    end
                    if (run) begin
                        state_d = StRun;
                    end else if (tick_rise) begin
                        state_d = StIdle;
                    end
                end
            end
            StHalted: begin
                if (!halt && !run) begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cpu_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cpu_en_q <= cpu_en_d;
        end
    end

    // -----------------------------------------------------------------------
    // Cycle counter: clear wins over a coincident increment
    // -----------------------------------------------------------------------
    logic [CNT_W-1:0] cycle_cnt_q;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_q <= '0;
        end else if (cnt_clr) begin
            cycle_cnt_q <= '0;
        end else if (cpu_en_q) begin
            cycle_cnt_q <= cycle_cnt_q + 1'b1;
        end
    end

    assign cpu_en    = cpu_en_q;
    assign cycle_cnt = cycle_cnt_q;
    assign state     = state_q;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
module tb_cpu_clk_ctrl;

    logic       clk_in   = 1'b0;
    logic       rst_n    = 1'b1;
    logic       tick_in  = 1'b0;
    logic       run      = 1'b0;
    logic       step_btn = 1'b0;
    logic       halt     = 1'b0;
    logic       cnt_clr  = 1'b0;
    logic       cpu_en;
    logic [7:0] cycle_cnt;
    logic [1:0] state;

    int         errors = 0;
    int         checks = 0;
    int         cyc    = 0;
    int         exp_q[$];
    int         mon_e;
    logic [7:0] exp_cnt = 8'h00;

    cpu_clk_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (8)
    ) dut (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .tick_in  (tick_in),
        .run      (run),
        .step_btn (step_btn),
        .halt     (halt),
        .cnt_clr  (cnt_clr),
        .cpu_en   (cpu_en),
        .cycle_cnt(cycle_cnt),
        .state    (state)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    // Scoreboard: each queued entry is the cycle in which a pulse must appear.
    always @(negedge clk_in) begin
        if (cpu_en === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: cpu_en=1 at cycle %0d, required no pulse", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e !== cyc) begin
                    errors++;
                    $display("FAIL pulse_timing: pulse at cycle %0d, required cycle %0d",
                             cyc, mon_e);
                end
            end
        end else if (exp_q.size() > 0 && exp_q[0] < cyc) begin
            checks++;
            errors++;
            mon_e = exp_q.pop_front();
            $display("FAIL missing_pulse: none by cycle %0d, required at cycle %0d", cyc, mon_e);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Drive one tick_in period; optionally queue the pulse it must produce.
    task automatic tick_pulse(input bit expect_pulse, input int hi, input int lo);
        @(negedge clk_in);
        tick_in = 1'b1;
        if (expect_pulse) begin
            exp_q.push_back(cyc + 3);
            exp_cnt = exp_cnt + 8'd1;
        end
        repeat (hi) @(negedge clk_in);
        tick_in = 1'b0;
        repeat (lo) @(negedge clk_in);
    endtask

    task automatic press_button();
        step_btn = 1'b1;
        repeat (12) @(negedge clk_in);
        step_btn = 1'b0;
        repeat (12) @(negedge clk_in);
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (state !== 2'b00 || cpu_en !== 1'b0 || cycle_cnt !== 8'h00) begin
            errors++;
            $display("FAIL reset_async: state=%b cpu_en=%b cnt=%h, required 00 0 00",
                     state, cpu_en, cycle_cnt);
        end
        repeat (3) @(negedge clk_in);
        rst_n = 1'b1;
        repeat (5) @(negedge clk_in);
    endtask

    task automatic test_idle_tick();
        tick_pulse(1'b0, 10, 10);
        checks++;
        if (state !== 2'b00 || cycle_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL idle_tick: state=%b cnt=%h, required 00 %h", state, cycle_cnt, exp_cnt);
        end
    endtask

    task automatic test_run();
        run = 1'b1;
        for (int i = 0; i < 5; i++) tick_pulse(1'b1, 10, 10);
        checks++;
        if (state !== 2'b01) begin
            errors++;
            $display("FAIL run_state: state=%b, required 01", state);
        end
        checks++;
        if (cycle_cnt !== 8'd5) begin
            errors++;
            $display("FAIL run_count: cnt=%h, required 05", cycle_cnt);
        end
        run = 1'b0;
        repeat (2) @(negedge clk_in);
        checks++;
        if (state !== 2'b00) begin
            errors++;
            $display("FAIL run_to_idle: state=%b, required 00", state);
        end
    endtask

    task automatic test_step_bounce();
        cnt_clr = 1'b1;
        @(negedge clk_in);
        cnt_clr = 1'b0;
        exp_cnt = 8'h00;
        for (int i = 0; i < 5; i++) begin
            repeat (2) @(negedge clk_in);
            step_btn = ~step_btn;
        end
        checks++;
        if (state !== 2'b00) begin
            errors++;
            $display("FAIL bounce_ignored: state=%b, required 00", state);
        end
        repeat (12) @(negedge clk_in);
        checks++;
        if (state !== 2'b10) begin
            errors++;
            $display("FAIL step_entered: state=%b, required 10", state);
        end
        tick_pulse(1'b1, 10, 10);
        checks++;
        if (state !== 2'b00 || cycle_cnt !== 8'd1) begin
            errors++;
            $display("FAIL step_done: state=%b cnt=%h, required 00 01", state, cycle_cnt);
        end
        step_btn = 1'b0;
        repeat (12) @(negedge clk_in);
        checks++;
        if (state !== 2'b00) begin
            errors++;
            $display("FAIL release_no_step: state=%b, required 00", state);
        end
    endtask

    task automatic test_halt_race();
        run = 1'b1;
        repeat (2) @(negedge clk_in);
        tick_pulse(1'b1, 10, 10);
        @(negedge clk_in);
        tick_in = 1'b1;
        repeat (2) @(negedge clk_in);
        halt = 1'b1;   // coincides with the cycle tick_rise is seen
        repeat (3) @(negedge clk_in);
        checks++;
        if (state !== 2'b11 || cycle_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL halt_race: state=%b cnt=%h, required 11 %h", state, cycle_cnt, exp_cnt);
        end
        repeat (5) @(negedge clk_in);
        tick_in = 1'b0;
        repeat (10) @(negedge clk_in);
        halt = 1'b0;
        repeat (3) @(negedge clk_in);
        checks++;
        if (state !== 2'b11) begin
            errors++;
            $display("FAIL halted_run_high: state=%b, required 11", state);
        end
        run = 1'b0;
        repeat (2) @(negedge clk_in);
        checks++;
        if (state !== 2'b00) begin
            errors++;
            $display("FAIL halted_release: state=%b, required 00", state);
        end
    endtask

    task automatic test_wrap_clear();
        int n;
        cnt_clr = 1'b1;
        @(negedge clk_in);
        cnt_clr = 1'b0;
        exp_cnt = 8'h00;
        run = 1'b1;
        for (int i = 0; i < 255; i++) tick_pulse(1'b1, 3, 3);
        repeat (2) @(negedge clk_in);
        checks++;
        if (cycle_cnt !== 8'hFF) begin
            errors++;
            $display("FAIL preload: cnt=%h, required ff", cycle_cnt);
        end
        tick_pulse(1'b1, 3, 3);
        repeat (2) @(negedge clk_in);
        checks++;
        if (cycle_cnt !== 8'h00) begin
            errors++;
            $display("FAIL wrap: cnt=%h, required 00", cycle_cnt);
        end
        tick_pulse(1'b1, 3, 3);
        repeat (2) @(negedge clk_in);
        checks++;
        if (cycle_cnt !== 8'h01) begin
            errors++;
            $display("FAIL after_wrap: cnt=%h, required 01", cycle_cnt);
        end
        @(negedge clk_in);
        tick_in = 1'b1;
        n = cyc;
        exp_q.push_back(n + 3);
        repeat (3) @(negedge clk_in);
        cnt_clr = 1'b1;  // same cycle cpu_en is high
        @(negedge clk_in);
        cnt_clr = 1'b0;
        exp_cnt = 8'h00;
        checks++;
        if (cycle_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL clear_priority: cnt=%h, required 00", cycle_cnt);
        end
        repeat (4) @(negedge clk_in);
        tick_in = 1'b0;
        repeat (5) @(negedge clk_in);
        run = 1'b0;
        repeat (2) @(negedge clk_in);
    endtask

    task automatic test_reset_midop();
        run = 1'b1;
        tick_pulse(1'b1, 10, 10);
        @(negedge clk_in);
        tick_in = 1'b1;
        @(negedge clk_in);
        rst_n = 1'b0;
        #1;
        checks++;
        if (state !== 2'b00 || cpu_en !== 1'b0 || cycle_cnt !== 8'h00) begin
            errors++;
            $display("FAIL reset_midop: state=%b cpu_en=%b cnt=%h, required 00 0 00",
                     state, cpu_en, cycle_cnt);
        end
        exp_cnt = 8'h00;
        repeat (3) @(negedge clk_in);
        rst_n = 1'b1;
        repeat (8) @(negedge clk_in);
        tick_in = 1'b0;
        repeat (10) @(negedge clk_in);
        checks++;
        if (state !== 2'b01 || cycle_cnt !== 8'h00) begin
            errors++;
            $display("FAIL reset_no_pending: state=%b cnt=%h, required 01 00", state, cycle_cnt);
        end
        tick_pulse(1'b1, 10, 10);
        checks++;
        if (cycle_cnt !== 8'h01) begin
            errors++;
            $display("FAIL reset_first_rise: cnt=%h, required 01", cycle_cnt);
        end
        run = 1'b0;
        repeat (2) @(negedge clk_in);
    endtask

    task automatic test_step_run_halted();
        run = 1'b1;
        repeat (2) @(negedge clk_in);
        press_button();
        checks++;
        if (state !== 2'b01 || cycle_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL step_in_run: state=%b cnt=%h, required 01 %h", state, cycle_cnt, exp_cnt);
        end
        halt = 1'b1;
        repeat (2) @(negedge clk_in);
        press_button();
        checks++;
        if (state !== 2'b11 || cycle_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL step_in_halted: state=%b cnt=%h, required 11 %h",
                     state, cycle_cnt, exp_cnt);
        end
        halt = 1'b0;
        run  = 1'b0;
        repeat (2) @(negedge clk_in);
        checks++;
        if (state !== 2'b00) begin
            errors++;
            $display("FAIL final_idle: state=%b, required 00", state);
        end
    endtask

    initial begin
        test_reset();
        test_idle_tick();
        test_run();
        test_step_bounce();
        test_halt_race();
        test_wrap_clear();
        test_reset_midop();
        test_step_run_halted();
        repeat (5) @(negedge clk_in);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d pulses outstanding, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
